pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 117 +++++++++++
 tb/tb_pc_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, stall hold, branch redirect with flush pulse.
// Optional macro PC_GEN_MISALIGN_CHECK_EN traps odd branch targets into HALT with a sticky error.
module pc_gen #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned PC_INC       = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [15:0] i_mem_addr,
  output logic [15:0] pc_plus_inc,
  output logic        fetch_valid,
  output logic        flush_fetch,
  output logic        halted,
  output logic        misalign_err
);

  localparam int unsigned CntW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [15:0] IncVal = 16'(PC_INC);
  localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fv_q, fv_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  logic            br_misalign;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  assign br_misalign = br_target[0];
`else
  assign br_misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    err_d    = err_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (br_taken) begin
          if (br_misalign) begin
            // Trap instead of redirecting; PC keeps the pre-branch address.
            state_d  = StHalt;
            halted_d = 1'b1;
            err_d    = 1'b1;
            cnt_d    = '0;
          end else begin
            pc_d  = {br_target[15:1], 1'b0};
            cnt_d = FlushLoad;
          end
        end else if (halt_req) begin
          state_d  = StHalt;
          halted_d = 1'b1;
          cnt_d    = '0;
        end else if (!stall) begin
          pc_d = pc_q + IncVal;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
      end
      StHalt: begin
        if (resume) begin
          state_d  = StRun;
          halted_d = 1'b0;
          pc_d     = pc_q + IncVal;
        end
      end
      default: state_d = StBoot;
    endcase
    flush_d = (cnt_d != '0);
    fv_d    = (state_d == StRun) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign i_mem_addr   = pc_q;
  assign pc_plus_inc  = pc_q + IncVal;
  assign fetch_valid  = fv_q;
  assign flush_fetch  = flush_q;
  assign halted       = halted_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: each cycle pushes the expected post-edge outputs, then pops and checks.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt_req;
  logic        resume;
  logic [15:0] i_mem_addr;
  logic [15:0] pc_plus_inc;
  logic        fetch_valid;
  logic        flush_fetch;
  logic        halted;
  logic        misalign_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic        fv;
    logic        fl;
    logic        ht;
    logic        er;
  } exp_t;

  exp_t sb_q[$];

`ifdef PC_GEN_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  pc_gen dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .i_mem_addr   (i_mem_addr),
    .pc_plus_inc  (pc_plus_inc),
    .fetch_valid  (fetch_valid),
    .flush_fetch  (flush_fetch),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus, queue the expected state after the edge, then compare.
  task automatic step(input string tag, input logic rst, input logic st, input logic br,
                      input logic [15:0] tgt, input logic hr, input logic rs,
                      input logic [15:0] ea, input logic efv, input logic efl,
                      input logic eht, input logic eer);
    exp_t e;
    reset     = rst;
    stall     = st;
    br_taken  = br;
    br_target = tgt;
    halt_req  = hr;
    resume    = rs;
    sb_q.push_back('{addr: ea, fv: efv, fl: efl, ht: eht, er: eer});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".addr"}, i_mem_addr, e.addr);
    check({tag, ".ppi"}, pc_plus_inc, e.addr + 16'd2);
    check({tag, ".fv"}, {15'd0, fetch_valid}, {15'd0, e.fv});
    check({tag, ".flush"}, {15'd0, flush_fetch}, {15'd0, e.fl});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, e.ht});
    check({tag, ".err"}, {15'd0, misalign_err}, {15'd0, e.er});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    halt_req = 1'b0; resume = 1'b0;

    // Reset, BOOT, then free run
    step("rst",   1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    step("boot",  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      step("run", 0, 0, 0, 16'h0000, 0, 0, 16'(2 * i), 1, 0, 0, 0);

    // Branch from 0010 to 0040
    step("br40",  0, 0, 1, 16'h0040, 0, 0, 16'h0040, 0, 1, 0, 0);
    step("br40b", 0, 0, 0, 16'h0000, 0, 0, 16'h0042, 0, 1, 0, 0);
    step("br40c", 0, 0, 0, 16'h0000, 0, 0, 16'h0044, 1, 0, 0, 0);
    step("br40d", 0, 0, 0, 16'h0000, 0, 0, 16'h0046, 1, 0, 0, 0);

    // Wrap walk via redirect to FFFC
    step("brfc",  0, 0, 1, 16'hFFFC, 0, 0, 16'hFFFC, 0, 1, 0, 0);
    step("wrap1", 0, 0, 0, 16'h0000, 0, 0, 16'hFFFE, 0, 1, 0, 0);
    step("wrap2", 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);
    step("wrap3", 0, 0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0, 0);

    // Stall with a simultaneous redirect; counter holds while stalled
    step("to20a", 0, 0, 1, 16'h001C, 0, 0, 16'h001C, 0, 1, 0, 0);
    step("to20b", 0, 0, 0, 16'h0000, 0, 0, 16'h001E, 0, 1, 0, 0);
    step("to20c", 0, 0, 0, 16'h0000, 0, 0, 16'h0020, 1, 0, 0, 0);
    step("stl1",  0, 1, 0, 16'h0000, 0, 0, 16'h0020, 1, 0, 0, 0);
    step("stl2",  0, 1, 1, 16'h0080, 0, 0, 16'h0080, 0, 1, 0, 0);
    step("stl3",  0, 1, 0, 16'h0000, 0, 0, 16'h0080, 0, 1, 0, 0);
    step("stl4",  0, 0, 0, 16'h0000, 0, 0, 16'h0082, 0, 1, 0, 0);
    step("stl5",  0, 0, 0, 16'h0000, 0, 0, 16'h0084, 1, 0, 0, 0);

    // Halt at 0030, inputs ignored, then resume
    step("to30a", 0, 0, 1, 16'h002C, 0, 0, 16'h002C, 0, 1, 0, 0);
    step("to30b", 0, 0, 0, 16'h0000, 0, 0, 16'h002E, 0, 1, 0, 0);
    step("to30c", 0, 0, 0, 16'h0000, 0, 0, 16'h0030, 1, 0, 0, 0);
    step("hlt",   0, 0, 0, 16'h0000, 1, 0, 16'h0030, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++)
      step("hltign", 0, i[0], 1, 16'h0100, 1, 0, 16'h0030, 0, 0, 1, 0);
    step("resm",  0, 0, 0, 16'h0000, 0, 1, 16'h0032, 1, 0, 0, 0);
    step("rsrun", 0, 0, 0, 16'h0000, 0, 1, 16'h0034, 1, 0, 0, 0);

    // Halt entry during a flush clears the pending flush
    step("brfl",  0, 0, 1, 16'h0200, 0, 0, 16'h0200, 0, 1, 0, 0);
    step("hltfl", 0, 0, 0, 16'h0000, 1, 0, 16'h0200, 0, 0, 1, 0);
    step("rsfl",  0, 0, 0, 16'h0000, 0, 1, 16'h0202, 1, 0, 0, 0);

    // Reset while halted
    step("hlt2",  0, 0, 0, 16'h0000, 1, 0, 16'h0202, 0, 0, 1, 0);
    step("rsthl", 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    step("boot2", 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0);

    // Odd branch target at 0050
    step("to50a", 0, 0, 1, 16'h004C, 0, 0, 16'h004C, 0, 1, 0, 0);
    step("to50b", 0, 0, 0, 16'h0000, 0, 0, 16'h004E, 0, 1, 0, 0);
    step("to50c", 0, 0, 0, 16'h0000, 0, 0, 16'h0050, 1, 0, 0, 0);
    if (MisEn) begin
      step("mis",   0, 0, 1, 16'h0051, 0, 0, 16'h0050, 0, 0, 1, 1);
      step("misrs", 0, 0, 0, 16'h0000, 0, 1, 16'h0052, 1, 0, 0, 1);
    end else begin
      step("odd",   0, 0, 1, 16'h0051, 0, 0, 16'h0050, 0, 1, 0, 0);
      step("oddb",  0, 0, 0, 16'h0000, 0, 0, 16'h0052, 0, 1, 0, 0);
    end

    // Reset mid-flush clears everything, including the sticky error
    step("brrst", 0, 0, 1, 16'h0300, 0, 0, 16'h0300, 0, 1, 0, MisEn);
    step("rstfl", 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
